// File: rtl/mux8_pkg.sv
// ----------------------------------------------------------------------------
// mux8_pkg : shared widths and word types for the 8:1 read-path selector
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mux8_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int NUM_IN    = 8;
  localparam int SEL_W     = 3;

  typedef logic [WIDTH_DEF-1:0] word_t;
  typedef word_t [NUM_IN-1:0]   word_arr_t;
endpackage

`default_nettype wire

// File: rtl/mux2_1.sv
// ----------------------------------------------------------------------------
// mux2_1 : combinational 2:1 word selector, out = sel ? i1 : i0
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mux2_1
  import mux8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? i1 : i0;

endmodule

`default_nettype wire

// File: rtl/mux4_1.sv
// ----------------------------------------------------------------------------
// mux4_1 : combinational 4:1 word selector built from three mux2_1 leaves
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mux4_1
  import mux8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0][WIDTH-1:0] i,
  input  logic [1:0]            sel,
  output logic [WIDTH-1:0]      out
);

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;

  // First rank resolves sel[0] within each pair, second rank picks the pair.
  mux2_1 #(.WIDTH(WIDTH)) u_lo  (.i0(i[0]), .i1(i[1]), .sel(sel[0]), .out(w_lo));
  mux2_1 #(.WIDTH(WIDTH)) u_hi  (.i0(i[2]), .i1(i[3]), .sel(sel[0]), .out(w_hi));
  mux2_1 #(.WIDTH(WIDTH)) u_top (.i0(w_lo), .i1(w_hi), .sel(sel[1]), .out(out));

endmodule

`default_nettype wire

// File: rtl/mux8_1_reg.sv
// ----------------------------------------------------------------------------
// mux8_1_reg : registered 8:1 word selector (mux4_1 x2 -> mux2_1) with valid
//              MUX8_SEL_REG_EN adds an input register stage (latency 2)
// Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mux8_1_reg
  import mux8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0][WIDTH-1:0] i,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         in_valid,
  output logic [WIDTH-1:0]             out,
  output logic                         out_valid
);

  logic [NUM_IN-1:0][WIDTH-1:0] w_i;
  logic [SEL_W-1:0]             w_sel;
  logic                         w_valid;
  logic [WIDTH-1:0]             w_v0;
  logic [WIDTH-1:0]             w_v1;
  logic [WIDTH-1:0]             w_y;
  logic [WIDTH-1:0]             r_out;
  logic                         r_out_valid;

`ifdef MUX8_SEL_REG_EN
  logic [NUM_IN-1:0][WIDTH-1:0] r_i;
  logic [SEL_W-1:0]             r_sel;
  logic                         r_in_valid;

  // Unconditional capture: the tree always sees last cycle's request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i        <= '0;
      r_sel      <= '0;
      r_in_valid <= 1'b0;
    end else begin
      r_i        <= i;
      r_sel      <= sel;
      r_in_valid <= in_valid;
    end
  end

  assign w_i     = r_i;
  assign w_sel   = r_sel;
  assign w_valid = r_in_valid;
`else
  assign w_i     = i;
  assign w_sel   = sel;
  assign w_valid = in_valid;
`endif

  mux4_1 #(.WIDTH(WIDTH)) u_mux_lo (.i(w_i[3:0]), .sel(w_sel[1:0]), .out(w_v0));
  mux4_1 #(.WIDTH(WIDTH)) u_mux_hi (.i(w_i[7:4]), .sel(w_sel[1:0]), .out(w_v1));
  mux2_1 #(.WIDTH(WIDTH)) u_mux_top (.i0(w_v0), .i1(w_v1), .sel(w_sel[2]), .out(w_y));

  // Data holds when idle; valid tracks the request every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_valid;
      if (w_valid) begin
        r_out <= w_y;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux8_1_reg.sv
// ----------------------------------------------------------------------------
// tb_mux8_1_reg : randomized bench for mux8_1_reg with a queue-based reference
// Revision      : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mux8_1_reg;

  localparam int W = 64;
`ifdef MUX8_SEL_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0][W-1:0] din = '0;
  logic [2:0]      sel = '0;
  logic            in_valid = 1'b0;
  logic [W-1:0]    out;
  logic            out_valid;

  logic [W-1:0]    m2_i0, m2_i1, m2_out;
  logic            m2_sel;
  logic [3:0][W-1:0] m4_i;
  logic [1:0]      m4_sel;
  logic [W-1:0]    m4_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux8_1_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i(din), .sel(sel), .in_valid(in_valid),
    .out(out), .out_valid(out_valid)
  );

  mux2_1 #(.WIDTH(W)) u_leaf2 (.i0(m2_i0), .i1(m2_i1), .sel(m2_sel), .out(m2_out));
  mux4_1 #(.WIDTH(W)) u_leaf4 (.i(m4_i), .sel(m4_sel), .out(m4_out));

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a request is the word i[sel] tagged with in_valid; it reaches
  // the output LAT edges after it is presented.
  typedef struct packed { logic v; logic [W-1:0] d; } req_t;
  req_t         pipe[$];
  req_t         r_head;
  logic [W-1:0] exp_out = '0;
  logic         exp_valid = 1'b0;

  task automatic model_clear();
    pipe.delete();
    for (int k = 0; k < LAT - 1; k++) pipe.push_back('0);
    exp_out   = '0;
    exp_valid = 1'b0;
  endtask

  initial model_clear();
  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
    end else begin
      pipe.push_back({in_valid, din[sel]});
      r_head    = pipe.pop_front();
      exp_valid = r_head.v;
      if (r_head.v) exp_out = r_head.d;
    end
  end

  always @(negedge clk) begin
    chk("model_out", out, exp_out);
    chk("model_valid", {63'b0, out_valid}, {63'b0, exp_valid});
  end

  logic [W-1:0] sweep_v [8] = '{64'd64357, 64'd26000, 64'd24556, 64'd12328,
                                64'd63, 64'd31, 64'd132346, 64'd7};
  logic [W-1:0] wide_v  [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};
  logic [2:0]   wide_s  [2] = '{3'd5, 3'd4};

  initial begin
    // Reset held with a live request pending
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) din[k] = {$urandom, $urandom};
    sel = 3'd3;
    repeat (3) @(negedge clk);
    chk("reset_out", out, '0);
    chk("reset_valid", {63'b0, out_valid}, 64'd0);
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("first_valid", {63'b0, out_valid}, 64'd1);
    chk("first_out", out, din[3]);

    // Full sweep, pipelined one select per cycle
    for (int k = 0; k < 8; k++) din[k] = sweep_v[k];
    for (int k = 0; k < 8 + LAT; k++) begin
      @(negedge clk);
      if (k >= LAT) chk($sformatf("sweep%0d", k - LAT), out, sweep_v[k - LAT]);
      if (k < 8) sel = 3'(k);
    end

    // Hold after capturing index 6
    sel = 3'd6;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sel = 3'd1;
    repeat (LAT) @(negedge clk);
    chk("hold_out", out, 64'd132346);
    chk("hold_valid", {63'b0, out_valid}, 64'd0);

    // Full-width patterns
    din[5] = wide_v[0];
    din[4] = wide_v[1];
    in_valid = 1'b1;
    for (int k = 0; k < 2 + LAT; k++) begin
      @(negedge clk);
      if (k >= LAT) chk($sformatf("wide%0d", k - LAT), out, wide_v[k - LAT]);
      if (k < 2) sel = wide_s[k];
    end

    // Asynchronous reset between edges
    sel = 3'd7;
    in_valid = 1'b1;
    repeat (LAT) @(negedge clk);
    chk("pre_areset_out", out, 64'd7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out", out, '0);
    chk("areset_valid", {63'b0, out_valid}, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    repeat (400) begin
      for (int k = 0; k < 8; k++) din[k] = {$urandom, $urandom};
      sel = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);

    // Leaf modules
    m2_i0 = 64'd5; m2_i1 = 64'd9; m2_sel = 1'b0;
    #1 chk("mux2_sel0", m2_out, 64'd5);
    m2_sel = 1'b1;
    #1 chk("mux2_sel1", m2_out, 64'd9);
    m4_i[0] = 64'd10; m4_i[1] = 64'd20; m4_i[2] = 64'd30; m4_i[3] = 64'd40;
    for (int k = 0; k < 4; k++) begin
      m4_sel = 2'(k);
      #1 chk($sformatf("mux4_sel%0d", k), m4_out, 64'(10 * (k + 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
